// File: rtl/diff_scan_unit.sv
// diff_scan_unit: multi-cycle first/last differing-bit finder with Hamming count.
// Scans x = a ^ b CHUNK bits per cycle, always visiting all WIDTH/CHUNK chunks
// so latency is fixed. Mode 0 reports the lowest differing bit, mode 1 the
// highest.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    request, accepted only while ready=1
//   mode     0 = lowest differing bit, 1 = highest differing bit
//   a, b     WIDTH-bit operands, sampled on the accepting edge
//   ready    high in IDLE
//   busy     high while scanning
//   done     one-cycle pulse, results valid in that cycle
//   found    at least one bit differs
//   index    selected differing bit position, 0 when found=0
//   hamming  number of differing bits
module diff_scan_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH),
  localparam int unsigned HAM_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] index,
  output logic [HAM_W-1:0] hamming
);

  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned POS_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam int unsigned PC_W  = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] x_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt;

  logic             last_chunk;
  logic [CNT_W-1:0] chunk_idx;
  logic [IDX_W-1:0] chunk_base;
  logic [CHUNK-1:0] chunk;
  logic [PC_W-1:0]  chunk_pop;
  logic [POS_W-1:0] chunk_pos;
  logic             chunk_any;

  // Chunk selection: mode 1 walks from the top chunk downward.
  assign last_chunk = (cnt == CNT_W'(NCH - 1));
  assign chunk_idx  = mode_q ? (CNT_W'(NCH - 1) - cnt) : cnt;
  assign chunk_base = IDX_W'(32'(chunk_idx) * CHUNK);
  assign chunk      = x_q[chunk_base +: CHUNK];
  assign chunk_any  = |chunk;

  // Per-chunk popcount and lowest/highest set position within the chunk.
  always_comb begin
    chunk_pop = '0;
    chunk_pos = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      chunk_pop = chunk_pop + PC_W'(chunk[i]);
      if (mode_q && chunk[i]) begin
        chunk_pos = POS_W'(i);
      end
      if (!mode_q && chunk[CHUNK-1-i]) begin
        chunk_pos = POS_W'(CHUNK - 1 - i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (last_chunk) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_SCAN:  busy  = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Operand capture, chunk counter and result accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      mode_q  <= 1'b0;
      cnt     <= '0;
      found   <= 1'b0;
      index   <= '0;
      hamming <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_q     <= a ^ b;
            mode_q  <= mode;
            cnt     <= '0;
            found   <= 1'b0;
            index   <= '0;
            hamming <= '0;
          end
        end
        S_SCAN: begin
          hamming <= hamming + HAM_W'(chunk_pop);
          // First chunk with a set bit wins; later chunks only add to hamming.
          if (!found && chunk_any) begin
            found <= 1'b1;
            index <= chunk_base + IDX_W'(chunk_pos);
          end
          cnt <= last_chunk ? '0 : cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_diff_scan_unit.sv
// Testbench for diff_scan_unit: a 32/8 instance and a 16/16 instance.
// Expected results are queued when an operation is launched and compared
// by a monitor whenever done pulses.
module tb_diff_scan_unit;

  typedef struct packed {
    logic       found;
    logic [4:0] index;
    logic [5:0] ham;
  } res32_t;

  typedef struct packed {
    logic       found;
    logic [3:0] index;
    logic [4:0] ham;
  } res16_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start32 = 1'b0;
  logic        mode32 = 1'b0;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;
  logic        ready32, busy32, done32, found32;
  logic [4:0]  index32;
  logic [5:0]  ham32;

  logic        start16 = 1'b0;
  logic        mode16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        ready16, busy16, done16, found16;
  logic [3:0]  index16;
  logic [4:0]  ham16;

  int tests = 0;
  int failed = 0;
  res32_t q32[$];
  res16_t q16[$];

  always #5 clk = ~clk;

  diff_scan_unit #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .found(found32),
    .index(index32), .hamming(ham32)
  );

  diff_scan_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .found(found16),
    .index(index16), .hamming(ham16)
  );

  // Reference: global lowest/highest set bit of x plus popcount.
  function automatic res32_t model32(input logic [31:0] x, input logic m);
    res32_t r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) begin
        if (m || !r.found) r.index = 5'(i);
        r.found = 1'b1;
        r.ham   = r.ham + 6'd1;
      end
    end
    return r;
  endfunction

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (done32) begin
      tests++;
      if (q32.size() == 0) begin
        failed++;
        $display("FAIL sb32_unexpected_done: got done with empty queue, expected no done");
      end else begin
        res32_t e;
        e = q32.pop_front();
        if ({found32, index32, ham32} !== e) begin
          failed++;
          $display("FAIL sb32_result: got f=%0d i=%0d h=%0d expected f=%0d i=%0d h=%0d",
                   found32, index32, ham32, e.found, e.index, e.ham);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done16) begin
      tests++;
      if (q16.size() == 0) begin
        failed++;
        $display("FAIL sb16_unexpected_done: got done with empty queue, expected no done");
      end else begin
        res16_t e;
        e = q16.pop_front();
        if ({found16, index16, ham16} !== e) begin
          failed++;
          $display("FAIL sb16_result: got f=%0d i=%0d h=%0d expected f=%0d i=%0d h=%0d",
                   found16, index16, ham16, e.found, e.index, e.ham);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Launch one operation on the 32-bit unit and queue its expected result.
  task automatic do_start32(input logic [31:0] av, input logic [31:0] bv, input logic m);
    @(posedge clk);
    #1;
    a32 = av; b32 = bv; mode32 = m; start32 = 1'b1;
    q32.push_back(model32(av ^ bv, m));
    @(posedge clk);
    #1;
    start32 = 1'b0;
  endtask

  // Count edges from the accepting edge until done; note busy/ready during scan.
  task automatic wait32(output int k, output bit bok);
    k = 0;
    bok = 1'b1;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (!done32 && (!busy32 || ready32)) bok = 1'b0;
    end while (!done32 && k < 20);
  endtask

  task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic m,
                      output int k, output bit bok, output res32_t r);
    do_start32(av, bv, m);
    wait32(k, bok);
    r = {found32, index32, ham32};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({ready32, busy32, done32, found32, index32, ham32} !== {4'b1000, 5'd0, 6'd0}) begin
      failed++;
      $display("FAIL reset32: got r=%0d b=%0d d=%0d f=%0d i=%0d h=%0d expected r=1 rest 0",
               ready32, busy32, done32, found32, index32, ham32);
    end
    tests++;
    if ({ready16, busy16, done16, found16, index16, ham16} !== {4'b1000, 4'd0, 5'd0}) begin
      failed++;
      $display("FAIL reset16: got r=%0d b=%0d d=%0d expected r=1 b=0 d=0",
               ready16, busy16, done16);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_bit;
    int k; bit bok; res32_t r;
    op32(32'h0000_0100, 32'h0, 1'b0, k, bok, r);
    tests++;
    if (k !== 4) begin failed++; $display("FAIL latency32: got %0d expected 4", k); end
    tests++;
    if (bok !== 1'b1) begin failed++; $display("FAIL busy_during_scan: got 0 expected 1"); end
    tests++;
    if (r !== {1'b1, 5'd8, 6'd1}) begin
      failed++;
      $display("FAIL single_bit: got f=%0d i=%0d h=%0d expected f=1 i=8 h=1", r.found, r.index, r.ham);
    end
    @(negedge clk);
    tests++;
    if ({ready32, busy32, done32} !== 3'b100) begin
      failed++;
      $display("FAIL ready_after_done: got r=%0d b=%0d d=%0d expected r=1 b=0 d=0", ready32, busy32, done32);
    end
    tests++;
    if ({found32, index32, ham32} !== {1'b1, 5'd8, 6'd1}) begin
      failed++;
      $display("FAIL result_hold: got f=%0d i=%0d h=%0d expected f=1 i=8 h=1", found32, index32, ham32);
    end
  endtask

  task automatic test_mode;
    int k; bit bok; res32_t r;
    op32(32'h8000_0001, 32'h0, 1'b1, k, bok, r);
    tests++;
    if (r !== {1'b1, 5'd31, 6'd2}) begin
      failed++;
      $display("FAIL mode1_ends: got i=%0d h=%0d expected i=31 h=2", r.index, r.ham);
    end
    op32(32'h8000_0001, 32'h0, 1'b0, k, bok, r);
    tests++;
    if (r !== {1'b1, 5'd0, 6'd2}) begin
      failed++;
      $display("FAIL mode0_ends: got i=%0d h=%0d expected i=0 h=2", r.index, r.ham);
    end
  endtask

  task automatic test_equal_allones;
    int k; bit bok; res32_t r;
    op32(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, k, bok, r);
    tests++;
    if (k !== 4 || r !== '0) begin
      failed++;
      $display("FAIL equal_ops: got k=%0d f=%0d i=%0d h=%0d expected k=4 all 0", k, r.found, r.index, r.ham);
    end
    op32(32'hFFFF_FFFF, 32'h0, 1'b0, k, bok, r);
    tests++;
    if (r !== {1'b1, 5'd0, 6'd32}) begin
      failed++;
      $display("FAIL allones_m0: got i=%0d h=%0d expected i=0 h=32", r.index, r.ham);
    end
    op32(32'hFFFF_FFFF, 32'h0, 1'b1, k, bok, r);
    tests++;
    if (r !== {1'b1, 5'd31, 6'd32}) begin
      failed++;
      $display("FAIL allones_m1: got i=%0d h=%0d expected i=31 h=32", r.index, r.ham);
    end
  endtask

  task automatic test_start_ignored;
    int k; bit bok; bit quiet;
    do_start32(32'h00F0_0000, 32'h0010_0000, 1'b0);
    a32 = 32'h1; b32 = 32'h0; mode32 = 1'b1; start32 = 1'b1;
    wait32(k, bok);
    start32 = 1'b0;
    tests++;
    if ({k[5:0], found32, index32, ham32} !== {6'd4, 1'b1, 5'd21, 6'd3}) begin
      failed++;
      $display("FAIL start_ignored: got k=%0d i=%0d h=%0d expected k=4 i=21 h=3", k, index32, ham32);
    end
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done32 || busy32) quiet = 1'b0;
    end
    tests++;
    if (quiet !== 1'b1) begin failed++; $display("FAIL no_second_op: got activity expected idle"); end
  endtask

  task automatic test_rst_abort;
    bit quiet;
    @(posedge clk);
    #1;
    a32 = 32'h1; b32 = 32'h0; mode32 = 1'b0; start32 = 1'b1;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy32, found32, ham32} !== {1'b1, 1'b1, 6'd1}) begin
      failed++;
      $display("FAIL pre_abort: got b=%0d f=%0d h=%0d expected b=1 f=1 h=1", busy32, found32, ham32);
    end
    @(posedge clk);
    #1;
    start32 = 1'b1;
    @(negedge clk);
    tests++;
    if ({ready32, busy32, done32, found32, index32, ham32} !== {4'b1000, 5'd0, 6'd0}) begin
      failed++;
      $display("FAIL abort_state: got r=%0d b=%0d d=%0d f=%0d i=%0d h=%0d expected r=1 rest 0",
               ready32, busy32, done32, found32, index32, ham32);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start32 = 1'b0;
    @(negedge clk);
    tests++;
    if ({ready32, busy32} !== 2'b10) begin
      failed++;
      $display("FAIL rst_over_start: got r=%0d b=%0d expected r=1 b=0", ready32, busy32);
    end
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done32 || busy32) quiet = 1'b0;
    end
    tests++;
    if (quiet !== 1'b1) begin failed++; $display("FAIL no_done_after_abort: got activity expected idle"); end
  endtask

  task automatic test_chunk_eq_width;
    logic [15:0] av [2];
    logic [15:0] bv [2];
    logic        mv [2];
    res16_t      ev [2];
    av[0] = 16'h0030; bv[0] = 16'h0010; mv[0] = 1'b0; ev[0] = {1'b1, 4'd5, 5'd1};
    av[1] = 16'h8001; bv[1] = 16'h0000; mv[1] = 1'b1; ev[1] = {1'b1, 4'd15, 5'd2};
    for (int n = 0; n < 2; n++) begin
      int k;
      @(posedge clk);
      #1;
      a16 = av[n]; b16 = bv[n]; mode16 = mv[n]; start16 = 1'b1;
      q16.push_back(ev[n]);
      @(posedge clk);
      #1;
      start16 = 1'b0;
      k = 0;
      do begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end while (!done16 && k < 20);
      tests++;
      if (k !== 1) begin failed++; $display("FAIL latency16_%0d: got %0d expected 1", n, k); end
      tests++;
      if ({found16, index16, ham16} !== ev[n]) begin
        failed++;
        $display("FAIL result16_%0d: got f=%0d i=%0d h=%0d expected f=%0d i=%0d h=%0d",
                 n, found16, index16, ham16, ev[n].found, ev[n].index, ev[n].ham);
      end
    end
  endtask

  task automatic test_back_to_back;
    int d[3];
    int n;
    int c;
    @(posedge clk);
    #1;
    a32 = 32'h0001_0400; b32 = 32'h0; mode32 = 1'b1; start32 = 1'b1;
    repeat (3) q32.push_back(model32(32'h0001_0400, 1'b1));
    n = 0;
    c = 0;
    while (n < 3 && c < 60) begin
      @(negedge clk);
      c++;
      if (done32) begin
        d[n] = c;
        n++;
      end
    end
    start32 = 1'b0;
    tests++;
    if (n !== 3) begin
      failed++;
      $display("FAIL b2b_count: got %0d dones expected 3", n);
    end else begin
      tests++;
      if (d[1] - d[0] !== 6 || d[2] - d[1] !== 6) begin
        failed++;
        $display("FAIL b2b_period: got %0d,%0d expected 6,6", d[1] - d[0], d[2] - d[1]);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      int k; bit bok; res32_t r; res32_t e;
      logic [31:0] av, mask;
      logic m;
      av   = $urandom;
      mask = $urandom & $urandom & $urandom;
      m    = 1'($urandom_range(1, 0));
      e    = model32(mask, m);
      op32(av, av ^ mask, m, k, bok, r);
      tests++;
      if (k !== 4 || r !== e) begin
        failed++;
        $display("FAIL random_%0d: got k=%0d f=%0d i=%0d h=%0d expected k=4 f=%0d i=%0d h=%0d",
                 n, k, r.found, r.index, r.ham, e.found, e.index, e.ham);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_bit;
    test_mode;
    test_equal_allones;
    test_start_ignored;
    test_rst_abort;
    test_chunk_eq_width;
    test_back_to_back;
    test_random;
    repeat (10) @(negedge clk);
    tests++;
    if (q32.size() !== 0 || q16.size() !== 0) begin
      failed++;
      $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", q32.size(), q16.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/diff_scan_unit.md
Name: diff_scan_unit

Overview:
- Parametrised sequential successor to the single-cycle first-differing-bit finder used in the datapath.
- Compares two WIDTH-bit operands CHUNK bits per cycle.
- Reports the lowest (mode 0) or highest (mode 1) differing bit index, a found flag, and the Hamming distance.
- Sits beside the ALU as a multi-cycle helper with a ready/start/done handshake. Usable by compare/branch-analysis logic without a long combinational priority chain.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits examined per scan cycle; NCH = WIDTH/CHUNK scan cycles.
- IDX_W, $clog2(WIDTH), width of the index output (derived localparam).
- HAM_W, $clog2(WIDTH+1), width of the Hamming-count output (derived localparam).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only on an edge where ready=1
- mode  input  1  0 = lowest differing bit, 1 = highest differing bit
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ready  output  1  high in IDLE only
- busy  output  1  high in SCAN
- done  output  1  one-cycle pulse; results valid in that cycle
- found  output  1  at least one bit differs
- index  output  IDX_W  bit position selected per mode; 0 when found=0
- hamming  output  HAM_W  count of differing bits (popcount of a^b)

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset state:
  - state=IDLE, ready=1, busy=0, done=0, found=0, index=0, hamming=0.
  - Internal xor register and chunk counter are cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on an edge with start=1:
  - Latch x = a^b and the mode.
  - Clear the accumulators and set the chunk counter to 0.
  - Clear found, index and hamming.
- SCAN, one chunk per edge for NCH edges:
  - Chunk order: mode 0 goes chunk 0 (bits CHUNK-1:0) upward; mode 1 goes chunk NCH-1 downward.
  - hamming += popcount(chunk).
  - At the first chunk holding a set bit: found <= 1; index <= chunk_base + lowest set position (mode 0) or highest set position (mode 1).
  - Later chunks never overwrite index.
  - No early exit: all NCH chunks are always scanned, so latency is fixed and hamming is complete.
- SCAN -> DONE after the NCH-th chunk edge.
- DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Latency: done is high in the cycle beginning NCH edges after the accepting edge. Throughput is one operation per NCH+2 cycles.
- Results (found, index, hamming) hold after done until the next accepted start clears them. They update during SCAN and are valid only when done=1.
- start while busy=1 or in DONE is ignored. Operands and mode are not re-sampled mid-scan, and changes on a, b or mode during SCAN have no effect.
- a==b: found=0, index=0, hamming=0.
- All bits differ: hamming=WIDTH exactly. HAM_W must hold WIDTH with no wrap.
- rst asserted at any state, including mid-SCAN or DONE:
  - Next state is IDLE with all outputs at reset values.
  - done is not produced for the aborted operation.
  - rst takes priority over start on the same edge.
- CHUNK=WIDTH degenerates to one scan cycle, so done appears 1 cycle after accept.
- Widths: chunk_base = counter*CHUNK computed at IDX_W bits; no truncation permitted for legal parameters.

Test Plan:
1. WIDTH=32, CHUNK=8; a=0x00000100, b=0, mode=0, start pulse -> busy for 4 cycles, done 4 cycles after accept; found=1, index=8, hamming=1; ready returns 1 the cycle after done.
2. a=0x80000001, b=0: mode=1 -> index=31, hamming=2; repeat with mode=0 -> index=0, hamming=2.
3. a=b=0xDEADBEEF -> done after 4 cycles with found=0, index=0, hamming=0. Then a=0xFFFFFFFF, b=0 -> hamming=32, index=0 (mode 0) / 31 (mode 1).
4. Accept a=0x00F00000, b=0x00100000, mode=0 (x=0x00E00000), then during SCAN drive start=1 with a=1, b=0 -> second start ignored; result index=21, hamming=3; no second done.
5. Accept any operation, assert rst on the 2nd SCAN cycle -> next cycle IDLE, ready=1, found/index/hamming=0, no done pulse. start on the same edge as rst -> not accepted.
6. WIDTH=16, CHUNK=16; a=0x0030, b=0x0010, mode=0 -> done 1 cycle after accept, index=5, hamming=1, found=1.
